// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline-stage register with optional 2-entry skid buffer
// and synchronous flush to a configurable bubble payload.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W     = 96,
  parameter int unsigned       SKID       = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        level
);

  localparam bit USE_SKID = (SKID != 0);

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        level_q, level_d;
  logic              in_ready_q, in_ready_d;
  logic              accept;

  // State and payload registers; reset drops any held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_q      <= BUBBLE_VAL;
      skid_q      <= BUBBLE_VAL;
      out_valid_q <= 1'b0;
      level_q     <= 2'd0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Next-state: single register or main+skid FSM, flush overrides everything.
  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    out_valid_d = out_valid_q;
    level_d     = level_q;
    in_ready_d  = in_ready_q;
    accept      = 1'b0;

    if (!USE_SKID) begin
      accept      = in_valid & (~out_valid_q | out_ready);
      if (accept) main_d = in_data;
      out_valid_d = accept | (out_valid_q & ~out_ready);
      state_d     = out_valid_d ? ST_FULL : ST_EMPTY;
      level_d     = {1'b0, out_valid_d};
      in_ready_d  = 1'b1;
    end else begin
      accept = in_valid & in_ready_q;
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = in_data;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && out_ready) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = ST_SKID_FULL;
          end else if (out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID_FULL: begin
          if (out_ready) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      out_valid_d = (state_d != ST_EMPTY);
      in_ready_d  = (state_d != ST_SKID_FULL);
      level_d     = (state_d == ST_SKID_FULL) ? 2'd2 : {1'b0, out_valid_d};
    end

    if (flush) begin
      state_d     = ST_EMPTY;
      main_d      = BUBBLE_VAL;
      skid_d      = BUBBLE_VAL;
      out_valid_d = 1'b0;
      level_d     = 2'd0;
      in_ready_d  = 1'b1;
    end
  end

  // Without a skid buffer, ready must see this cycle's out_ready.
  assign in_ready  = USE_SKID ? in_ready_q : (~out_valid_q | out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign level     = level_q;

endmodule
